// File: rtl/conv_stream_engine.sv
// conv_stream_engine: streaming convolution MAC that emits one saturated result per (y, x, ch).
module conv_stream_engine #(
    parameter int DATA_WIDTH         = 16,
    parameter int ACCUMULATION_WIDTH = 32,
    parameter int FEATURE_MAP_WIDTH  = 4,
    parameter int FEATURE_MAP_HEIGHT = 4,
    parameter int INPUT_NB_CHANNELS  = 2,
    parameter int OUTPUT_NB_CHANNELS = 2,
    parameter int KERNEL_SIZE        = 3,
    parameter int OUTPUT_SHIFT       = 0
) (
    input  logic                                  clk,
    input  logic                                  arst,
    input  logic                                  start,
    output logic                                  running,
    input  logic signed [DATA_WIDTH-1:0]          a_input,
    input  logic                                  a_zero_flag,
    input  logic                                  a_valid,
    output logic                                  a_ready,
    input  logic signed [DATA_WIDTH-1:0]          b_input,
    input  logic                                  b_valid,
    output logic                                  b_ready,
    output logic signed [DATA_WIDTH-1:0]          output_data,
    output logic                                  output_valid,
    output logic [$clog2(FEATURE_MAP_WIDTH)-1:0]  output_x,
    output logic [$clog2(FEATURE_MAP_HEIGHT)-1:0] output_y,
    output logic [$clog2(OUTPUT_NB_CHANNELS)-1:0] output_ch
);
    localparam int N  = INPUT_NB_CHANNELS * KERNEL_SIZE * KERNEL_SIZE;
    localparam int SW = $clog2(N + 1);
    localparam int XW = $clog2(FEATURE_MAP_WIDTH);
    localparam int YW = $clog2(FEATURE_MAP_HEIGHT);
    localparam int CW = $clog2(OUTPUT_NB_CHANNELS);
    localparam logic signed [ACCUMULATION_WIDTH-1:0] SAT_MAX =
        {{(ACCUMULATION_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACCUMULATION_WIDTH-1:0] SAT_MIN =
        {{(ACCUMULATION_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, EMIT} state_t;

    state_t                         state, state_nxt;
    logic signed [ACCUMULATION_WIDTH-1:0] acc, acc_sh;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic [SW-1:0]                  step;
    logic [XW-1:0]                  x;
    logic [YW-1:0]                  y;
    logic [CW-1:0]                  ch;
    logic                           fire, last_step, last_x, last_y, last_ch;

    assign fire         = state == RUN && a_valid && b_valid;
    assign a_ready      = fire;
    assign b_ready      = fire;
    assign prod         = a_input * b_input;
    assign last_step    = step == SW'(N - 1);
    assign last_x       = x == XW'(FEATURE_MAP_WIDTH - 1);
    assign last_y       = y == YW'(FEATURE_MAP_HEIGHT - 1);
    assign last_ch      = ch == CW'(OUTPUT_NB_CHANNELS - 1);
    assign running      = state != IDLE;
    assign output_valid = state == EMIT;
    assign acc_sh       = acc >>> OUTPUT_SHIFT;
    assign output_data  = !output_valid ? '0 :
                          acc_sh > SAT_MAX ? SAT_MAX[DATA_WIDTH-1:0] :
                          acc_sh < SAT_MIN ? SAT_MIN[DATA_WIDTH-1:0] : acc_sh[DATA_WIDTH-1:0];

    always_comb begin
        state_nxt = state;
        state_nxt = state == IDLE ? (start ? RUN : IDLE) :
                    state == RUN  ? (fire && last_step ? EMIT : RUN) :
                    (last_x && last_y && last_ch ? IDLE : RUN);
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state     <= IDLE;
            acc       <= '0;
            step      <= '0;
            x         <= '0;
            y         <= '0;
            ch        <= '0;
            output_x  <= '0;
            output_y  <= '0;
            output_ch <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                acc       <= '0;
                step      <= '0;
                x         <= '0;
                y         <= '0;
                ch        <= '0;
                output_x  <= '0;
                output_y  <= '0;
                output_ch <= '0;
            end else if (fire) begin
                acc  <= a_zero_flag ? acc : acc + ACCUMULATION_WIDTH'(prod);
                step <= last_step ? '0 : step + SW'(1);
                // coordinates are latched here so they stay stable until the next result
                if (last_step) begin
                    output_x  <= x;
                    output_y  <= y;
                    output_ch <= ch;
                end
            end else if (state == EMIT) begin
                acc  <= '0;
                step <= '0;
                ch   <= last_ch ? '0 : ch + CW'(1);
                x    <= !last_ch ? x : last_x ? '0 : x + XW'(1);
                y    <= !(last_ch && last_x) ? y : last_y ? '0 : y + YW'(1);
            end
        end
    end
endmodule

// File: tb/tb_conv_stream_engine.sv
// tb_conv_stream_engine: randomized stimulus against a sum-of-products reference model.
module tb_conv_stream_engine;
    localparam int DW = 16, AW = 32, W = 2, H = 2, CIN = 2, COUT = 2, K = 3, SH = 1;
    localparam int N = CIN * K * K, OUTS = W * H * COUT, TOT = N * OUTS;

    logic clk = 0, arst = 1, start = 0, running;
    logic signed [DW-1:0] a_input = 0, b_input = 0, output_data;
    logic a_zero_flag = 0, a_valid = 0, a_ready, b_valid = 0, b_ready, output_valid;
    logic [0:0] output_x, output_y, output_ch;

    logic signed [DW-1:0] wa [TOT];
    logic signed [DW-1:0] wb [TOT];
    bit wz [TOT];
    int n_checks = 0, n_fail = 0, out_total = 0, base = 0;

    conv_stream_engine #(
        .DATA_WIDTH(DW), .ACCUMULATION_WIDTH(AW), .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H),
        .INPUT_NB_CHANNELS(CIN), .OUTPUT_NB_CHANNELS(COUT), .KERNEL_SIZE(K), .OUTPUT_SHIFT(SH)
    ) dut (
        .clk(clk), .arst(arst), .start(start), .running(running),
        .a_input(a_input), .a_zero_flag(a_zero_flag), .a_valid(a_valid), .a_ready(a_ready),
        .b_input(b_input), .b_valid(b_valid), .b_ready(b_ready),
        .output_data(output_data), .output_valid(output_valid),
        .output_x(output_x), .output_y(output_y), .output_ch(output_ch)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Result k: wrapped sum of its N products, shifted, then clamped to the output range.
    function automatic longint exp_val(input int k);
        longint s = 0;
        logic signed [AW-1:0] acc;
        for (int j = 0; j < N; j++)
            if (!wz[k*N+j]) s += longint'(wa[k*N+j]) * longint'(wb[k*N+j]);
        acc = s[AW-1:0];
        s = longint'(acc >>> SH);
        return s > 32767 ? 32767 : s < -32768 ? -32768 : s;
    endfunction

    always @(negedge clk) begin
        int k;
        if (!arst) begin
            check("rdy_eq", a_ready, b_ready);
            if (!(a_valid && b_valid)) check("stall_rdy", a_ready, 0);
            if (output_valid) begin
                k = out_total - base;
                check("out_idx", k < OUTS, 1);
                if (k < OUTS) begin
                    check("data", output_data, exp_val(k));
                    check("y", output_y, k / (W * COUT));
                    check("x", output_x, (k / COUT) % W);
                    check("ch", output_ch, k % COUT);
                end
                out_total++;
            end
        end
    end

    task automatic fill(input int kind);
        for (int i = 0; i < TOT; i++) begin
            wz[i] = kind == 1 ? bit'(i % 2) : kind >= 4 ? ($urandom_range(0, 3) == 0) : 1'b0;
            case (kind)
                2: begin wa[i] = 16'sd32767; wb[i] = 16'sd32767; end
                3: begin wa[i] = -16'sd32768; wb[i] = 16'sd32767; end
                4: begin wa[i] = DW'(int'($urandom_range(0, 120)) - 60); wb[i] = DW'(int'($urandom_range(0, 120)) - 60); end
                5: begin wa[i] = DW'($urandom); wb[i] = DW'($urandom); end
                default: begin wa[i] = 16'sd3; wb[i] = 16'sd2; end
            endcase
        end
    endtask

    // mode: 0 always valid, 1 random valids, 2 b stalled 5 cycles, 3 abort after 3 outputs, 4 random start pulses
    task automatic run_layer(input int kind, input int mode);
        int idx = 0, cyc = 0, stalls = 0;
        bit fire, pend = 0, av, bv;
        fill(kind);
        base = out_total;
        start = 1;
        while (idx < TOT && cyc < 4000) begin
            av = mode == 1 || mode == 4 ? $urandom_range(0, 3) != 0 : 1'b1;
            bv = mode == 1 || mode == 4 ? $urandom_range(0, 3) != 0 : 1'b1;
            if (mode == 2 && idx == 5 && stalls < 5) begin bv = 0; stalls++; end
            a_valid = av;
            b_valid = bv;
            a_input = av ? wa[idx] : DW'($urandom);
            b_input = bv ? wb[idx] : DW'($urandom);
            a_zero_flag = av ? wz[idx] : $urandom_range(0, 1) == 1;
            @(negedge clk);
            fire = a_ready;
            if (pend) check("latency", output_valid, 1);
            pend = 0;
            @(posedge clk);
            #1;
            start = mode == 4 ? $urandom_range(0, 1) == 1 : 1'b0;
            if (fire) begin
                pend = idx % N == N - 1;
                idx++;
            end
            cyc++;
            if (mode == 3 && out_total - base == 3) begin
                arst = 1;
                start = 0;
                #1;
                check("abort_running", running, 0);
                check("abort_ready", a_ready, 0);
                check("abort_ovalid", output_valid, 0);
                check("abort_odata", output_data, 0);
                check("abort_coord", {output_x, output_y, output_ch}, 0);
                repeat (2) @(posedge clk);
                #1 arst = 0;
                repeat (10) @(posedge clk);
                #1;
                check("abort_quiet", out_total - base, 3);
                check("abort_idle", running, 0);
                return;
            end
        end
        start = 0;
        check("timeout", idx, TOT);
        @(negedge clk);
        if (pend) check("latency", output_valid, 1);
        check("running_emit", running, 1);
        @(negedge clk);
        check("running_fall", running, 0);
        check("out_count", out_total - base, OUTS);
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_valid = 1;
        b_valid = 1;
        #3;
        check("rst_running", running, 0);
        check("rst_ready", a_ready | b_ready, 0);
        check("rst_ovalid", output_valid, 0);
        check("rst_odata", output_data, 0);
        check("rst_coord", {output_x, output_y, output_ch}, 0);
        @(posedge clk);
        #1 arst = 0;
        run_layer(0, 0);
        run_layer(1, 0);
        run_layer(0, 2);
        run_layer(2, 0);
        run_layer(3, 0);
        run_layer(4, 1);
        run_layer(5, 1);
        run_layer(4, 4);
        run_layer(5, 3);
        run_layer(4, 1);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
